// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle over WIDTH cycles.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W    = WIDTH;
    localparam int unsigned W2   = 2 * WIDTH;
    localparam int unsigned CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_div_q, is_div_d;
    logic          neg_lo_q, neg_lo_d;
    logic          neg_hi_q, neg_hi_d;
    logic          dz_q, dz_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [W-1:0]  acc_hi_q, acc_hi_d;
    logic [W-1:0]  acc_lo_q, acc_lo_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          done_q, done_d;

    // Operand magnitudes; op[0]=0 selects the signed variants
    logic         sgn_op, a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;

    always_comb begin
        sgn_op = ~op[0];
        a_neg  = sgn_op & a[W-1];
        b_neg  = sgn_op & b[W-1];
        a_mag  = a_neg ? (~a + W'(1)) : a;
        b_mag  = b_neg ? (~b + W'(1)) : b;
    end

    // One iteration of each datapath, computed from the accumulator pair
    logic [W:0]   mul_sum;
    logic [W-1:0] mul_hi, mul_lo;
    logic [W:0]   rem_sh, div_diff;
    logic [W-1:0] div_rem, div_quo;

    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi   = mul_sum[W:1];
        mul_lo   = {mul_sum[0], acc_lo_q[W-1:1]};
        rem_sh   = {acc_hi_q, acc_lo_q[W-1]};
        div_diff = rem_sh - {1'b0, opnd_q};
        if (div_diff[W]) begin
            div_rem = rem_sh[W-1:0];
            div_quo = {acc_lo_q[W-2:0], 1'b0};
        end else begin
            div_rem = div_diff[W-1:0];
            div_quo = {acc_lo_q[W-2:0], 1'b1};
        end
    end

    // Sign fix-up applied to the final iteration's result
    logic [W2-1:0] prod_u, prod_s;
    logic [W-1:0]  quo_s, rem_s, res_hi, res_lo;

    always_comb begin
        prod_u = {mul_hi, mul_lo};
        prod_s = neg_lo_q ? (~prod_u + W2'(1)) : prod_u;
        quo_s  = dz_q ? '1 : (neg_lo_q ? (~div_quo + W'(1)) : div_quo);
        rem_s  = neg_hi_q ? (~div_rem + W'(1)) : div_rem;
        res_hi = is_div_q ? rem_s : prod_s[W2-1:W];
        res_lo = is_div_q ? quo_s : prod_s[W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    if (!op[2]) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        is_div_d = op[1];
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                        dz_d     = op[1] && (b == '0);
                        acc_hi_d = '0;
                        // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier
                        opnd_d   = op[1] ? b_mag : a_mag;
                        acc_lo_d = op[1] ? a_mag : b_mag;
                    end else if (!op[1]) begin
                        if (op[0]) begin
                            lo_d = a;
                        end else begin
                            hi_d = a;
                        end
                    end
                end
            end
            RUN: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    acc_hi_d = is_div_q ? div_rem : mul_hi;
                    acc_lo_d = is_div_q ? div_quo : mul_lo;
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        hi_d    = res_hi;
                        lo_d    = res_lo;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations checked against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset, start, kill;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] cur_hi, cur_lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .kill  (kill),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference: plain 64-bit arithmetic, returns {hi, lo}
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: return 64'(sx * sy);
            3'd1: return {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; presents a request for the next edge
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Called #1 after the accepting edge; waits WIDTH edges and checks the result
    task automatic wait_done(input string tag, input logic [63:0] exp, input bit noisy);
        int busy_n = 0;
        int done_n = 0;
        bit held   = 1'b1;
        if (busy) busy_n++;
        if (done) done_n++;
        if (hi !== cur_hi || lo !== cur_lo) held = 1'b0;
        for (int c = 1; c <= W; c++) begin
            if (noisy && c < W) begin
                start = 1'($urandom);
                op    = 3'($urandom);
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c < W) begin
                if (busy) busy_n++;
                if (done) done_n++;
                if (hi !== cur_hi || lo !== cur_lo) held = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, ":busy_cycles"}, 64'(busy_n), 64'(W));
        check({tag, ":early_done"}, 64'(done_n), 64'd0);
        check({tag, ":hilo_held"}, 64'(held), 64'd1);
        check({tag, ":done"}, {63'd0, done}, 64'd1);
        check({tag, ":busy_end"}, {63'd0, busy}, 64'd0);
        check({tag, ":result"}, {hi, lo}, exp);
        cur_hi = exp[63:32];
        cur_lo = exp[31:0];
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk);
        #1;
        check({tag, ":done_drop"}, {63'd0, done}, 64'd0);
        check({tag, ":idle_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] rexp;

        reset = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        #2 reset = 1'b0;
        #10;
        check("rst:busy", {63'd0, busy}, 64'd0);
        check("rst:done", {63'd0, done}, 64'd0);
        check("rst:hilo", {hi, lo}, 64'd0);
        cur_hi = '0;
        cur_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult_m3x5", {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 1'b0);
        idle_cycle("mult_m3x5");

        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_done("multu_max_x2", {32'h0000_0001, 32'hFFFF_FFFE}, 1'b1);
        idle_cycle("multu_max_x2");

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_m7_2", {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("b2b_div:done_low", {63'd0, done}, 64'd0);
        wait_done("div_ovf", {32'h0000_0000, 32'h8000_0000}, 1'b0);
        idle_cycle("div_ovf");

        issue(3'd3, 32'h1234_5678, 32'd0);
        wait_done("divu_by0", {32'h1234_5678, 32'hFFFF_FFFF}, 1'b1);
        idle_cycle("divu_by0");

        issue(3'd6, $urandom, $urandom);
        check("noop:busy", {63'd0, busy}, 64'd0);
        check("noop:hilo", {hi, lo}, {cur_hi, cur_lo});
        kill = 1'b1;
        issue(3'd4, 32'h5555_AAAA, $urandom);
        kill = 1'b0;
        check("idle_kill:busy", {63'd0, busy}, 64'd0);
        check("idle_kill:hilo", {hi, lo}, {cur_hi, cur_lo});

        issue(3'd0, $urandom, $urandom);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill10:busy", {63'd0, busy}, 64'd0);
        check("kill10:done", {63'd0, done}, 64'd0);
        check("kill10:hilo", {hi, lo}, {cur_hi, cur_lo});
        idle_cycle("kill10");

        issue(3'd4, 32'hDEAD_BEEF, $urandom);
        check("mthi:hilo", {hi, lo}, {32'hDEAD_BEEF, cur_lo});
        check("mthi:done", {63'd0, done}, 64'd0);
        cur_hi = 32'hDEAD_BEEF;
        issue(3'd5, 32'hCAFE_F00D, $urandom);
        check("mtlo:hilo", {hi, lo}, {cur_hi, 32'hCAFE_F00D});
        check("mtlo:busy", {63'd0, busy}, 64'd0);
        cur_lo = 32'hCAFE_F00D;

        issue(3'd1, $urandom, $urandom);
        repeat (W - 1) begin
            @(posedge clk);
            #1;
        end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_last:done", {63'd0, done}, 64'd0);
        check("kill_last:busy", {63'd0, busy}, 64'd0);
        check("kill_last:hilo", {hi, lo}, {cur_hi, cur_lo});

        issue(3'd1, $urandom, $urandom);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #3 reset = 1'b0;
        #1;
        check("rst_run:busy", {63'd0, busy}, 64'd0);
        check("rst_run:done", {63'd0, done}, 64'd0);
        check("rst_run:hilo", {hi, lo}, 64'd0);
        cur_hi = '0;
        cur_lo = '0;
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        ra = $urandom;
        rb = pick();
        issue(3'd3, ra, rb);
        wait_done("b2b_divu", model(3'd3, ra, rb), 1'b0);
        ra = $urandom;
        rb = $urandom;
        issue(3'd1, ra, rb);
        check("b2b_multu:done_low", {63'd0, done}, 64'd0);
        wait_done("b2b_multu", model(3'd1, ra, rb), 1'b0);
        idle_cycle("b2b_multu");

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = pick();
            rb = pick();
            issue(ro, ra, rb);
            if (ro >= 3'd4) begin
                if (ro == 3'd4) cur_hi = ra;
                else cur_lo = ra;
                check($sformatf("rnd%0d:mt", i), {hi, lo}, {cur_hi, cur_lo});
            end else begin
                rexp = model(ro, ra, rb);
                wait_done($sformatf("rnd%0d:op%0d", i, ro), rexp, 1'($urandom));
                if ($urandom_range(0, 1) == 1) idle_cycle($sformatf("rnd%0d", i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
